// File: rtl/kbd_event_ctrl.sv
// Bus-side PS/2 keyboard controller: drains the receiver FIFO with a paced pop
// handshake, folds E0/F0 prefixes into key events and serves them over STB/ACK.
module kbd_event_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic [1:0]  ADDR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  input  logic        kbd_ready,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_overflow,
  output logic        kbd_rdn,
  output logic        INT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_POP    = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          ovf_q, ovf_d;
  logic          int_en_q, int_en_d;
  logic          cap_en_q, cap_en_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q;
  logic [31:0]   dat_q, dat_d;
  logic          int_q;
  logic          rdn_q;

  logic [9:0]    mem_q [DEPTH];

  logic          acc, nonempty, full, push, pop;
  logic          wr_status, wr_ctrl;
  logic [31:0]   status_w, ctrl_w, rdata;

  logic unused_dat_i;
  assign unused_dat_i = ^{DAT_I[31:3], DAT_I[0]};

  // An access executes only on the first STB cycle; ACK then blocks repeats.
  assign acc       = STB & ~ack_q;
  assign nonempty  = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign wr_status = acc & WE & (ADDR == A_STATUS);
  assign wr_ctrl   = acc & WE & (ADDR == A_CTRL);
  assign pop       = acc & ~WE & (ADDR == A_DATA) & nonempty;
  assign push      = (state_q == S_POP) & (byte_q != B_EXT) & (byte_q != B_BRK);

  always_comb begin
    status_w          = '0;
    status_w[0]       = nonempty;
    status_w[1]       = full;
    status_w[2]       = ovf_q;
    status_w[3]       = (state_q != S_IDLE);
    status_w[CW+7:8]  = count_q;
  end

  assign ctrl_w = {30'b0, cap_en_q, int_en_q};

  always_comb begin
    rdata = '0;
    case (ADDR)
      A_DATA:   rdata = nonempty ? {22'b0, mem_q[rd_ptr_q]} : 32'h0;
      A_STATUS: rdata = status_w;
      A_CTRL:   rdata = ctrl_w;
      default:  rdata = '0;
    endcase
  end

  // Fetch sequencer: latch, pop strobe, then a settle cycle for the receiver.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE: begin
        if (cap_en_q && kbd_ready && (count_q < DEPTH_C)) begin
          byte_d  = kbd_data;
          state_d = S_POP;
        end
      end
      S_POP:    state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    if (state_q == S_POP) begin
      if (byte_q == B_EXT)      ext_d = 1'b1;
      else if (byte_q == B_BRK) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (wr_ctrl && !DAT_I[1]) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_comb begin
    int_en_d = int_en_q;
    cap_en_d = cap_en_q;
    if (wr_ctrl) begin
      int_en_d = DAT_I[0];
      cap_en_d = DAT_I[1];
    end
  end

  // A sticky overflow set beats a clear landing in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && DAT_I[2]) ovf_d = 1'b0;
    if (kbd_overflow)          ovf_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    dat_d = dat_q;
    if (acc)       dat_d = WE ? 32'h0 : rdata;
    else if (!STB) dat_d = 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      byte_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      ovf_q    <= 1'b0;
      int_en_q <= 1'b0;
      cap_en_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      int_q    <= 1'b0;
      rdn_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      ovf_q    <= ovf_d;
      int_en_q <= int_en_d;
      cap_en_q <= cap_en_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= STB;
      dat_q    <= dat_d;
      int_q    <= int_en_q & nonempty;
      rdn_q    <= (state_d != S_POP);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ext_q, brk_q, byte_q};
  end

  assign DAT_O   = dat_q;
  assign ACK     = ack_q;
  assign INT     = int_q;
  assign kbd_rdn = rdn_q;

endmodule
